// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/stall controller of the 5-stage RV32 core.
package hazard_pkg;

  // ResultSrcE value that marks the E-stage instruction as a load.
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  // E-stage operand forwarding selects.
  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_W  = 2'b01;  // W-stage result
  localparam logic [1:0] FWD_M  = 2'b10;  // M-stage ALU result

  // Data-memory wait sequencer states.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding comparator for one E-stage source operand.
// The M stage holds the younger result, so it wins over W. x0 never forwards.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_we_m,
  input  logic              i_we_w,
  output logic [1:0]        o_fwd
);

  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = i_we_m && (i_rd_m != '0) && (i_rd_m == i_rs);
  assign w_hit_w = i_we_w && (i_rd_w != '0) && (i_rd_w == i_rs);

  // Pick the youngest matching producer.
  always_comb begin
    o_fwd = FWD_RF;
    if (w_hit_m) begin
      o_fwd = FWD_M;
    end else if (w_hit_w) begin
      o_fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: load-use/branch/memory-wait stall and
// flush enables, E-stage forwarding selects, a memory wait FSM with timeout
// trap, and saturating stall/flush performance counters.
//
// Memory handshake: MemReqM is a level held while a load/store sits in M;
// mem_ready is a completion strobe meaning the access finishes this cycle.
// A stall is raised only while MemReqM=1 and mem_ready=0, so a same-cycle
// completion costs no extra cycle.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              mem_ready,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events,
  output hz_state_t         o_dbg_state
);

  // Wait counter is wide enough to hold TIMEOUT-1.
  localparam int WCNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  hz_state_t         r_state;
  hz_state_t         w_state_next;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_flush_events;

  logic              w_mem_stall;
  logic              w_load_use;
  logic              w_any_stall;
  logic              w_any_flush;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  assign w_mem_stall = MemReqM && !mem_ready;

  // A load in E whose destination feeds the D instruction needs one bubble.
  assign w_load_use = RegWriteE && (ResultSrcE == RESULT_SRC_MEM) &&
                      (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .i_rs   (Rs1E),
    .i_rd_m (RdM),
    .i_rd_w (RdW),
    .i_we_m (RegWriteM),
    .i_we_w (RegWriteW),
    .o_fwd  (w_fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .i_rs   (Rs2E),
    .i_rd_m (RdM),
    .i_rd_w (RdW),
    .i_we_m (RegWriteM),
    .i_we_w (RegWriteW),
    .o_fwd  (w_fwd_b)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: enter WAIT on an unfinished access, trap if it never ends.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          w_state_next = RUN;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_next = ERR;
        end
      end
      ERR: begin
        w_state_next = ERR;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  // Wait counter: counts WAIT cycles, zero everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if ((r_state == WAIT) && (w_state_next == WAIT)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Sticky timeout error, only cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_err <= 1'b0;
    end else if (w_state_next == ERR) begin
      r_mem_err <= 1'b1;
    end
  end

  // Stall/flush enables in priority order: reset, trap, memory wait, branch,
  // load-use. Branch beats load-use because the D instruction is wrong-path.
  // During a memory wait PCSrcE is simply ignored; E is frozen, so the branch
  // is still presented and taken on the release cycle.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!rst_n) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if ((r_state == ERR) || w_mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Forwarding selects are forced to the register file while in reset.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (rst_n) begin
      ForwardAE = w_fwd_a;
      ForwardBE = w_fwd_b;
    end
  end

  assign w_any_stall = StallF | StallD | StallE | StallM;
  assign w_any_flush = FlushD | FlushE;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_any_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_any_flush && (r_flush_events != '1)) begin
        r_flush_events <= r_flush_events + 1'b1;
      end
    end
  end

  assign mem_err      = r_mem_err;
  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (TIMEOUT shortened to 4).
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int REG_AW  = 5;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 32;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  localparam logic [6:0] CTL_IDLE  = 7'b0000_000;
  localparam logic [6:0] CTL_RESET = 7'b0000_111;
  localparam logic [6:0] CTL_MEM   = 7'b1111_001;
  localparam logic [6:0] CTL_BR    = 7'b0000_110;
  localparam logic [6:0] CTL_LU    = 7'b1100_010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic [1:0]        ResultSrcE;
  logic              PCSrcE, MemReqM, mem_ready;
  logic              StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              mem_err;
  logic [CNT_W-1:0]  stall_cycles, flush_events;
  hz_state_t         dbg_state;
  logic [6:0]        ctl;

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  hazard_ctrl #(.REG_AW(REG_AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .RdE          (RdE),
    .RdM          (RdM),
    .RdW          (RdW),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .ResultSrcE   (ResultSrcE),
    .PCSrcE       (PCSrcE),
    .MemReqM      (MemReqM),
    .mem_ready    (mem_ready),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
    .o_dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  // Bench-side model of the performance counters.
  logic [CNT_W-1:0] exp_stall = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; PCSrcE = 1'b0; MemReqM = 1'b0; mem_ready = 1'b0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; MemReqM = 1'b1;
    step();
    checks++;
    if (ctl !== CTL_RESET) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, CTL_RESET); end
    checks++;
    if (ForwardAE !== FWD_RF) begin errors++; $display("FAIL reset_fwd got %b exp %b", ForwardAE, FWD_RF); end
    checks++;
    if (stall_cycles !== '0 || flush_events !== '0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL reset_regs got %0d/%0d/%b exp 0/0/0", stall_cycles, flush_events, mem_err);
    end
    checks++;
    if (dbg_state !== RUN) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, RUN); end
    clear_inputs();
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (ctl !== CTL_IDLE || stall_cycles !== exp_stall || flush_events !== exp_flush) begin
      errors++; $display("FAIL post_reset got ctl %b cnt %0d/%0d exp %b 0/0", ctl, stall_cycles, flush_events, CTL_IDLE);
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
    settle();
    checks++;
    if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_m_prio got %b exp 10", ForwardAE); end
    checks++;
    if (ForwardBE !== 2'b00) begin errors++; $display("FAIL fwd_b_none got %b exp 00", ForwardBE); end
    RegWriteM = 1'b0;
    settle();
    checks++;
    if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_w got %b exp 01", ForwardAE); end
    RegWriteM = 1'b1; RdM = '0; RdW = '0; Rs1E = '0;
    settle();
    checks++;
    if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_x0 got %b exp 00", ForwardAE); end
    Rs2E = 5'd7; RdW = 5'd7; RdM = 5'd9;
    settle();
    checks++;
    if (ForwardBE !== 2'b01 || ForwardAE !== 2'b00) begin
      errors++; $display("FAIL fwd_b_w got %b/%b exp 00/01", ForwardAE, ForwardBE);
    end
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL fwd_no_stall got %b exp %b", ctl, CTL_IDLE); end
    clear_inputs();
    step();
  endtask

  task automatic test_load_use();
    clear_inputs();
    RegWriteE = 1'b1; ResultSrcE = RESULT_SRC_MEM; RdE = 5'd3; Rs2D = 5'd3; Rs1D = 5'd8;
    settle();
    checks++;
    if (ctl !== CTL_LU) begin errors++; $display("FAIL load_use_ctl got %b exp %b", ctl, CTL_LU); end
    step();
    exp_stall++; exp_flush++;
    // Load has moved to M; the consumer is now in E.
    clear_inputs();
    RdM = 5'd3; RegWriteM = 1'b1; Rs2E = 5'd3;
    settle();
    checks++;
    if (ForwardBE !== 2'b10 || ctl !== CTL_IDLE) begin
      errors++; $display("FAIL load_use_next got fwd %b ctl %b exp 10 %b", ForwardBE, ctl, CTL_IDLE);
    end
    checks++;
    if (stall_cycles !== exp_stall || flush_events !== exp_flush) begin
      errors++; $display("FAIL load_use_cnt got %0d/%0d exp %0d/%0d", stall_cycles, flush_events, exp_stall, exp_flush);
    end
    // Load into x0 never stalls.
    clear_inputs();
    RegWriteE = 1'b1; ResultSrcE = RESULT_SRC_MEM; RdE = 5'd0; Rs1D = 5'd0;
    settle();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL load_use_x0 got %b exp %b", ctl, CTL_IDLE); end
    // Non-load producer never stalls.
    RdE = 5'd4; Rs1D = 5'd4; ResultSrcE = 2'b00;
    settle();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL load_use_alu got %b exp %b", ctl, CTL_IDLE); end
    clear_inputs();
    step();
  endtask

  task automatic test_branch();
    clear_inputs();
    RegWriteE = 1'b1; ResultSrcE = RESULT_SRC_MEM; RdE = 5'd3; Rs2D = 5'd3; PCSrcE = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_BR) begin errors++; $display("FAIL branch_ctl got %b exp %b", ctl, CTL_BR); end
    step();
    exp_flush++;
    clear_inputs();
    settle();
    checks++;
    if (flush_events !== exp_flush || stall_cycles !== exp_stall) begin
      errors++; $display("FAIL branch_cnt got %0d/%0d exp %0d/%0d", stall_cycles, flush_events, exp_stall, exp_flush);
    end
    step();
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    MemReqM = 1'b1; mem_ready = 1'b0; PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (ctl !== CTL_MEM) begin errors++; $display("FAIL mem_wait_ctl%0d got %b exp %b", i, ctl, CTL_MEM); end
      step();
      exp_stall++;
      checks++;
      if (dbg_state !== WAIT) begin errors++; $display("FAIL mem_wait_state%0d got %0d exp %0d", i, dbg_state, WAIT); end
    end
    mem_ready = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_BR) begin errors++; $display("FAIL mem_release_branch got %b exp %b", ctl, CTL_BR); end
    step();
    exp_flush++;
    clear_inputs();
    settle();
    checks++;
    if (dbg_state !== RUN) begin errors++; $display("FAIL mem_back_run got %0d exp %0d", dbg_state, RUN); end
    checks++;
    if (stall_cycles !== exp_stall || flush_events !== exp_flush) begin
      errors++; $display("FAIL mem_wait_cnt got %0d/%0d exp %0d/%0d", stall_cycles, flush_events, exp_stall, exp_flush);
    end
  endtask

  task automatic test_zero_latency();
    clear_inputs();
    MemReqM = 1'b1; mem_ready = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL zero_lat_ctl got %b exp %b", ctl, CTL_IDLE); end
    step();
    checks++;
    if (dbg_state !== RUN || stall_cycles !== exp_stall) begin
      errors++; $display("FAIL zero_lat_state got %0d/%0d exp %0d/%0d", dbg_state, stall_cycles, RUN, exp_stall);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_timeout();
    hz_state_t exp_st;
    logic      exp_err;
    clear_inputs();
    MemReqM = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_stall++;
      exp_err = (i == 5);
      exp_st  = (i == 5) ? ERR : WAIT;
      checks++;
      if (mem_err !== exp_err || dbg_state !== exp_st) begin
        errors++; $display("FAIL timeout_edge%0d got err %b st %0d exp %b %0d", i, mem_err, dbg_state, exp_err, exp_st);
      end
    end
    checks++;
    if (stall_cycles !== exp_stall) begin errors++; $display("FAIL timeout_cnt got %0d exp %0d", stall_cycles, exp_stall); end
    // ERR holds everything regardless of the memory, forwarding still live.
    clear_inputs();
    mem_ready = 1'b1; Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_MEM || ForwardAE !== 2'b10) begin
      errors++; $display("FAIL err_hold got ctl %b fwd %b exp %b 10", ctl, ForwardAE, CTL_MEM);
    end
    step(); step();
    exp_stall = exp_stall + 2;
    checks++;
    if (dbg_state !== ERR || mem_err !== 1'b1 || stall_cycles !== exp_stall) begin
      errors++; $display("FAIL err_sticky got %0d/%b/%0d exp %0d/1/%0d", dbg_state, mem_err, stall_cycles, ERR, exp_stall);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_stall = '0; exp_flush = '0;
    checks++;
    if (mem_err !== 1'b0 || dbg_state !== RUN || ctl !== CTL_RESET || stall_cycles !== exp_stall) begin
      errors++; $display("FAIL err_reset got %b/%0d/%b/%0d exp 0/%0d/%b/0", mem_err, dbg_state, ctl, stall_cycles, RUN, CTL_RESET);
    end
    #1 rst_n = 1'b1;
    clear_inputs();
    step();
    checks++;
    if (ctl !== CTL_IDLE || mem_err !== 1'b0) begin errors++; $display("FAIL err_recover got %b/%b exp %b/0", ctl, mem_err, CTL_IDLE); end
  endtask

  task automatic test_async_reset_mid_wait();
    clear_inputs();
    MemReqM = 1'b1; mem_ready = 1'b0; PCSrcE = 1'b1;
    step(); step();
    exp_stall = exp_stall + 2;
    checks++;
    if (dbg_state !== WAIT || stall_cycles !== exp_stall) begin
      errors++; $display("FAIL async_pre got %0d/%0d exp %0d/%0d", dbg_state, stall_cycles, WAIT, exp_stall);
    end
    #3 rst_n = 1'b0;
    #1;
    exp_stall = '0; exp_flush = '0;
    checks++;
    if (ctl !== CTL_RESET) begin errors++; $display("FAIL async_ctl got %b exp %b", ctl, CTL_RESET); end
    checks++;
    if (dbg_state !== RUN || stall_cycles !== exp_stall || flush_events !== exp_flush || mem_err !== 1'b0) begin
      errors++; $display("FAIL async_regs got %0d/%0d/%0d/%b exp %0d/0/0/0", dbg_state, stall_cycles, flush_events, mem_err, RUN);
    end
    #2 rst_n = 1'b1;
    clear_inputs();
    step();
    checks++;
    if (ctl !== CTL_IDLE || dbg_state !== RUN || stall_cycles !== exp_stall) begin
      errors++; $display("FAIL async_after got %b/%0d/%0d exp %b/%0d/0", ctl, dbg_state, stall_cycles, CTL_IDLE, RUN);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_zero_latency();
    test_timeout();
    test_async_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32 core.
- Drives stall/flush enables of the F/D, D/E, E/M and M/W pipeline registers and the E-stage operand forwarding selects.
- Sequences multi-cycle data-memory accesses with a wait FSM and timeout.
- Keeps saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register-address width (matches Rd/Rs fields).
- TIMEOUT, 64, max cycles in WAIT before the error trap.
- CNT_W, 32, performance-counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- Rs1D, Rs2D  in  REG_AW  source registers of the D-stage instruction
- Rs1E, Rs2E  in  REG_AW  source registers of the E-stage instruction
- RdE, RdM, RdW  in  REG_AW  destination registers in E/M/W
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables in E/M/W
- ResultSrcE  in  2  result select in E (2'b01 = memory load)
- PCSrcE  in  1  taken branch/jump resolved in E
- MemReqM  in  1  load or store active in M
- mem_ready  in  1  data memory completes the M-stage access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  insert a bubble into the F/D, D/E and M/W registers
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 W result, 10 M ALU result
- mem_err  out  1  sticky memory-timeout error
- stall_cycles, flush_events  out  CNT_W  performance counters

Behaviour:
- Reset (rst_n low, async): state=RUN, wait counter 0, mem_err 0, both perf counters 0.
- While rst_n is low: all Stall*=0; FlushD=FlushE=FlushW=1; Forward*=00.
- FSM states: RUN, WAIT, ERR.
  - RUN->WAIT when MemReqM && !mem_ready.
  - WAIT->RUN when mem_ready.
  - WAIT->ERR when the wait counter reaches TIMEOUT-1 with mem_ready still low.
  - ERR is held until reset.
- Memory stall (combinational, any state except ERR): mem_stall = MemReqM && !mem_ready.
  - While mem_stall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
  - Load-use and branch actions are suppressed; PCSrcE stays frozen and is honoured on the release cycle.
  - Zero added latency: if mem_ready=1 in the same cycle as MemReqM, no stall.
- Wait counter: cleared in RUN; increments each WAIT cycle; cleared on the WAIT->RUN transition.
- ERR: all Stall*=1, FlushW=1, mem_err=1; forwarding still computed.
- Branch, when not mem-stalled: PCSrcE=1 -> FlushD=1, FlushE=1, StallF=StallD=0. Branch has priority over load-use, because the D instruction is wrong-path.
- Load-use, when not mem-stalled and PCSrcE=0:
  - Condition: RegWriteE && ResultSrcE==2'b01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - Action: StallF=StallD=1, FlushE=1.
  - Lasts exactly one cycle, since the load moves to M next cycle.
- Forwarding, per operand (A shown, B identical with Rs2E):
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
  - M has priority over W. Register x0 never forwards.
- stall_cycles: +1 on every clk where any Stall* is 1 (includes ERR); saturates at all-ones.
- flush_events: +1 on every clk where FlushD or FlushE is 1 (with rst_n high); saturates.
- All outputs except mem_err, the counters and the FSM are combinational from inputs and state.

Decomposition:
- Package hazard_pkg:
  - RESULT_SRC_MEM = 2'b01.
  - FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - typedef enum hz_state_t {RUN, WAIT, ERR}.
- Sub-module fwd_sel: pure combinational forwarding comparator, instantiated twice (A, B).

Test Plan:
- Forward priority: Rs1E=5, RdM=5/RegWriteM=1, RdW=5/RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Set RdM=RdW=Rs1E=0 -> 00.
- Load-use: ResultSrcE=01, RegWriteE=1, RdE=3, Rs2D=3 -> one cycle StallF=StallD=FlushE=1; next cycle (load in M, RdM=3) ForwardBE=10, no stall.
- Branch vs load-use: same load-use inputs plus PCSrcE=1 -> FlushD=FlushE=1, StallF=0; flush_events +1.
- Memory wait: MemReqM=1, mem_ready low 3 cycles then high -> all Stall*=1 and FlushW=1 for exactly 3 cycles, state RUN after; stall_cycles +3.
- Timeout: TIMEOUT=4, mem_ready never rises -> mem_err=1 on the 5th clk edge after entry; stays 1 with all stalls held until rst_n pulse clears everything.
- Async reset mid-WAIT: drop rst_n between clock edges -> outputs go immediately to FlushD/E/W=1, Stall*=0, counters 0, state RUN.
